// File: rtl/fact_ctrl_acc.sv
// rtl/fact_ctrl_acc.sv - factorial control FSM and product accumulator
module fact_ctrl_acc #(
  parameter int WIDTH = 32,
  parameter int N_MAX = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             go,
  input  logic [3:0]       n,
  input  logic [3:0]       cnt_q,
  output logic             load_cnt,
  output logic             cnt_en,
  output logic [3:0]       cnt_d,
  output logic [WIDTH-1:0] product,
  output logic             busy,
  output logic             done,
  output logic             err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2,
    S_ERR  = 2'd3
  } state_t;

  localparam logic [3:0] N_LIMIT = 4'(N_MAX);

  state_t           state_q;
  state_t           state_d;
  logic             n_ok;
  logic             cnt_more;
  logic [WIDTH-1:0] prod_mul;

  assign n_ok     = (n <= N_LIMIT);
  assign cnt_more = (cnt_q > 4'd1);
  assign cnt_d    = n;
  // Single unsigned WIDTH x 4 multiply; only the low WIDTH bits are kept.
  assign prod_mul = product * {{(WIDTH-4){1'b0}}, cnt_q};

  // State register; async reset returns straight to IDLE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // Next-state decode and counter strobes / status flags.
  always_comb begin
    state_d  = state_q;
    load_cnt = 1'b0;
    cnt_en   = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    err      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (go) begin
          if (n_ok) begin
            load_cnt = 1'b1;
            state_d  = S_RUN;
          end else begin
            state_d  = S_ERR;
          end
        end
      end
      S_RUN: begin
        busy = 1'b1;
        if (cnt_more) cnt_en  = 1'b1;
        else          state_d = S_DONE;
      end
      S_DONE: begin
        done = 1'b1;
        if (!go) state_d = S_IDLE;
      end
      S_ERR: begin
        err = 1'b1;
        if (!go) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // The counter must see no strobes while reset is asserted.
    if (!rst) begin
      load_cnt = 1'b0;
      cnt_en   = 1'b0;
    end
  end

  // Product accumulator: seeded on accept, multiplied while the count exceeds 1.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      product <= '0;
    end else begin
      case (state_q)
        S_IDLE: if (go) product <= n_ok ? WIDTH'(1) : '0;
        S_RUN:  if (cnt_more) product <= prod_mul;
        S_ERR:  product <= '0;
        default: product <= product;
      endcase
    end
  end

endmodule
